// File: rtl/ascon_pack.sv
// Shared ASCON definitions: state type, round constants, permutation modes
// and the three round-layer functions used by the round datapath.
package ascon_pack;

  localparam int NB_ROUNDS_MAX = 12;
  localparam logic [3:0] LAST_ROUND = 4'(NB_ROUNDS_MAX - 1);

  // Word 0 (x0) occupies the most significant 64 bits.
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [1:0] {
    P12 = 2'b00,
    P8  = 2'b01,
    P6  = 2'b10
  } type_perm_mode;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } type_perm_fsm;

  function automatic logic [7:0] round_constant(input logic [3:0] r);
    return {4'hf - r, r};
  endfunction

  // Shorter permutations reuse the tail of the p12 constant table.
  function automatic logic [3:0] first_round(input type_perm_mode m);
    case (m)
      P8:      return 4'd4;
      P6:      return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] t;
    t = {x, x} >> n;
    return t[63:0];
  endfunction

  function automatic type_state constant_addition(input type_state s, input logic [3:0] r);
    type_state o;
    o = s;
    o[2][7:0] = s[2][7:0] ^ round_constant(r);
    return o;
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  function automatic type_state substitution_layer(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0] ^ s[4];
    x4 = s[4] ^ s[3];
    x2 = s[2] ^ s[1];
    x1 = s[1];
    x3 = s[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic type_state diffusion_layer(input type_state s);
    type_state o;
    o[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    o[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    o[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    o[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    o[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    return o;
  endfunction

endpackage

// File: rtl/permutation_controller_if.sv
// Start/done handshake and state bus between the mode FSM and the permutation controller.
interface permutation_controller_if;
  import ascon_pack::*;

  logic       start_i;
  logic [1:0] mode_i;
  type_state  state_i;
  type_state  state_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, mode_i, state_i,
    input  state_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, mode_i, state_i,
    output state_o, round_o, busy_o, done_o
  );
endinterface

// File: rtl/permutation_controller_round.sv
// One ASCON round: constant addition, substitution, diffusion. Purely combinational.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  always_comb begin
    state_o = diffusion_layer(substitution_layer(constant_addition(state_i, round_i)));
  end

endmodule

// File: rtl/permutation_controller.sv
// Runs p12/p8/p6 one round per clock on the state register; done pulses one cycle after the last round.
// A start in DONE is taken immediately; starts during RUN are ignored.
module permutation_controller
  import ascon_pack::*;
(
  input logic                      clock_i,
  input logic                      resetb_i,
  permutation_controller_if.slave  bus
);

  type_perm_fsm  fsm_q, fsm_d;
  type_state     state_q, state_d, round_nxt;
  logic [3:0]    round_q, round_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  type_perm_mode mode_sel;

  ascon_round u_round (
    .state_i (state_q),
    .round_i (round_q),
    .state_o (round_nxt)
  );

  // The reserved encoding runs the full 12 rounds.
  assign mode_sel = (bus.mode_i == 2'b11) ? P12 : type_perm_mode'(bus.mode_i);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      RUN: begin
        state_d = round_nxt;
        if (round_q == LAST_ROUND) begin
          fsm_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      default: begin
        if (bus.start_i) begin
          state_d = bus.state_i;
          round_d = first_round(mode_sel);
          fsm_d   = RUN;
        end else begin
          fsm_d = IDLE;
        end
      end
    endcase
    busy_d = (fsm_d == RUN);
    done_d = (fsm_d == DONE);
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.state_o = state_q;
  assign bus.round_o = round_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;

endmodule

// File: tb/tb_permutation_controller.sv
// Bench for permutation_controller: timeline model built from a table-driven ASCON round, checked every cycle.
module tb_permutation_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic cmp_en   = 1'b0;

  permutation_controller_if bus ();

  permutation_controller dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  localparam logic [319:0] INIT = {64'h80400c0600000000, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f, 64'h0001020304050607,
                                   64'h08090a0b0c0d0e0f};
  localparam logic [319:0] ROUND0_OF_ZERO = {64'h001E0F00000000F0, 64'h00000001E0000770,
                                             64'h3FFFFFFFFFFFFF74, 64'h3C780000000000F0,
                                             64'h0000000000000000};

  logic [4:0] sbox_t [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                              5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                              5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                              5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Column-wise table lookup version of one round.
  function automatic logic [319:0] m_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    logic [319:0] res;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o   = sbox_t[col];
      for (int i = 0; i < 5; i++) y[i][b] = o[4 - i];
    end
    for (int i = 0; i < 5; i++)
      res[319 - 64*i -: 64] = y[i] ^ rr(y[i], rot_a[i]) ^ rr(y[i], rot_b[i]);
    return res;
  endfunction

  // Model: after an accepted start at t=0, cycle t shows trace[t]; t==n is the done cycle.
  logic [319:0] trace [13];
  logic [319:0] exp_state;
  logic [3:0]   exp_round;
  logic         exp_busy, exp_done;
  int           m_t = 100, m_n = 0, m_first = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_state = '0; exp_round = 4'd0; exp_busy = 1'b0; exp_done = 1'b0;
      m_t = 100; m_n = 0;
    end else begin
      if (m_t >= m_n && bus.start_i) begin
        m_n = (bus.mode_i == 2'b01) ? 8 : (bus.mode_i == 2'b10) ? 6 : 12;
        m_first = 12 - m_n;
        trace[0] = bus.state_i;
        for (int k = 1; k <= m_n; k++) trace[k] = m_round(trace[k-1], m_first + k - 1);
        m_t = 0;
      end else if (m_t < 100) begin
        m_t++;
      end
      if (m_t < m_n) begin
        exp_busy = 1'b1; exp_done = 1'b0;
        exp_round = 4'(m_first + m_t); exp_state = trace[m_t];
      end else if (m_t == m_n) begin
        exp_busy = 1'b0; exp_done = 1'b1;
        exp_round = 4'd11; exp_state = trace[m_n];
      end else begin
        exp_busy = 1'b0; exp_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_state", bus.state_o, exp_state);
      chk("cyc_round", 320'(bus.round_o), 320'(exp_round));
      chk("cyc_busy",  320'(bus.busy_o),  320'(exp_busy));
      chk("cyc_done",  320'(bus.done_o),  320'(exp_done));
    end
  end

  task automatic run(input logic [1:0] m, input logic [319:0] s, input int lat,
                     output logic [319:0] res);
    int cyc, nbusy;
    @(negedge clk);
    bus.mode_i = m; bus.state_i = s; bus.start_i = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.mode_i  = ~m;
    cyc = 0; nbusy = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (bus.done_o || cyc > 40) break;
      if (bus.busy_o) nbusy++;
    end
    chk("done_latency", 320'(cyc), 320'(lat));
    chk("busy_cycles", 320'(nbusy), 320'(lat - 1));
    res = bus.state_o;
    @(negedge clk);
  endtask

  logic [319:0] res12, res6, res8, res_rsv, res_again;

  initial begin
    bus.start_i = 1'b1;
    bus.mode_i  = 2'b00;
    bus.state_i = {$urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom};
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("model_round0_zero", m_round(320'h0, 0), ROUND0_OF_ZERO);

    run(2'b00, INIT, 13, res12);
    run(2'b10, INIT, 7,  res6);
    run(2'b01, INIT, 9,  res8);
    run(2'b11, INIT, 13, res_rsv);
    chk("reserved_eq_p12", res_rsv, res12);
    chk("p12_result_model", res12, trace[12]);

    begin : back_to_back
      int last, pulses;
      last = -1; pulses = 0;
      @(negedge clk);
      bus.mode_i = 2'b10; bus.state_i = ~INIT; bus.start_i = 1'b1;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (bus.done_o) begin
          if (last >= 0) chk("b2b_spacing", 320'(c - last), 320'd7);
          last = c;
          pulses++;
        end
      end
      bus.start_i = 1'b0;
      chk("b2b_pulses", 320'(pulses), 320'd4);
      repeat (10) @(negedge clk);
    end

    begin : reset_mid_run
      int cyc, d;
      @(negedge clk);
      bus.mode_i = 2'b00; bus.state_i = INIT; bus.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      cyc = 0;
      while (bus.round_o != 4'd5 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk("reached_round5", 320'(bus.round_o), 320'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", bus.state_o, 320'h0);
      chk("arst_round", 320'(bus.round_o), 320'd0);
      chk("arst_busy",  320'(bus.busy_o),  320'd0);
      chk("arst_done",  320'(bus.done_o),  320'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      repeat (16) begin
        @(negedge clk);
        if (bus.done_o) d++;
      end
      chk("no_done_after_abort", 320'(d), 320'd0);
      run(2'b00, INIT, 13, res_again);
      chk("rerun_p12", res_again, res12);
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/permutation_controller.md
Name: permutation_controller

Overview:
- Sequences the ASCON permutation p^a over a 320-bit state, one round per clock.
- Each round applies the datapath chain constant_addition -> substitution_layer -> diffusion_layer.
- Owns the state register, the round counter and the start/done handshake.
- Sits between the top-level ASCON-128 mode FSM (initialisation, associated data, plaintext, finalisation) and the round datapath. Supports p12, p8 and p6.

Parameters:
- NB_ROUNDS_MAX, 12, total round-constant table depth; the round index runs 0..NB_ROUNDS_MAX-1.

Ports:
- clock_i  input  1  system clock, rising edge.
- resetb_i  input  1  asynchronous active-low reset.
- start_i  input  1  request to run a permutation on state_i; sampled on the rising edge.
- mode_i  input  2  round count: 2'b00 = p12, 2'b01 = p8, 2'b10 = p6, 2'b11 reserved (treated as p12).
- state_i  input  320 (type_state)  state loaded when start_i is accepted.
- state_o  output  320 (type_state)  permutation state register.
- round_o  output  4  round index currently applied (round-constant selector).
- busy_o  output  1  high while rounds are executing.
- done_o  output  1  one-cycle pulse: state_o holds the final permuted state.

Behaviour:
- Reset (resetb_i low, asynchronous): state_o = 0, round_o = 4'd0, busy_o = 0, done_o = 0, FSM = IDLE. Reset mid-permutation aborts immediately; no done_o follows.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i = 1 at edge E0:
  - state_reg <= state_i.
  - round_reg <= first round: 0 (p12), 4 (p8), 6 (p6).
  - n_last latched from mode_i (mode_i is ignored afterwards).
  - FSM -> RUN.
- IDLE, start_i = 0: hold everything.
- RUN:
  - busy_o = 1.
  - Each edge: state_reg <= round(state_reg, round_reg), round_reg <= round_reg + 1.
  - On the edge where round_reg = 11 is applied, round_reg is left at 11 and FSM -> DONE.
- DONE:
  - done_o = 1 and busy_o = 0 for exactly one cycle.
  - state_o holds the result.
  - start_i = 1 in DONE is accepted exactly as from IDLE (back-to-back permutations, no bubble).
  - Otherwise FSM -> IDLE.
- Latency: start accepted at E0; done_o high in the cycle after edge E(n), where n = 12/8/6. Examples:
  - p12: busy_o high for cycles 1..12, done_o in cycle 13.
  - p6: done_o in cycle 7.
- start_i while in RUN: ignored, with no effect on the round count or state.
- state_o is stable outside RUN: it holds the last result in IDLE and DONE until the next accepted start.
- round_o equals round_reg at all times; in IDLE it holds its last value (11 after any completed run, 0 after reset).
- Round counter: 4-bit unsigned; never exceeds 11; no wrap-around is permitted.
- Round function datapath: purely combinational; the only registers are state_reg, round_reg and the FSM.

Decomposition:
- Shared package ascon_pack (already holds type_state and round_constant) gains:
  - type_perm_mode enumeration (P12, P8, P6).
  - type_perm_fsm enumeration (IDLE, RUN, DONE).
  - Constant NB_ROUNDS_MAX = 12.
  - First-round lookup function first_round(type_perm_mode) returning 4'd0 / 4'd4 / 4'd6.
- One sub-module: ascon_round.
  - Combinational; chains the existing constant_addition, substitution_layer and diffusion_layer.
  - Inputs: state, round_i. Output: next state.
  - permutation_controller instantiates one ascon_round and contains only registers and control.

Test Plan:
- Reset check: hold resetb_i low, drive start_i = 1 and a random state_i -> state_o = 0, round_o = 0, busy_o = 0, done_o = 0 throughout; after release, no activity until start_i.
- p12 latency and rounds: start_i with mode_i = 00 and the ASCON-128 init state (IV 0x80400c0600000000, K = 000102..0f, N = 000102..0f) -> round_o steps 0..11, busy_o high for 12 cycles, done_o in cycle 13; state_o matches the C golden model.
- p6 and p8: same stimulus with mode_i = 10, then 01 -> round_o sequences 6..11 and 4..11, done_o in cycles 7 and 9; state_o matches the golden p6/p8 results.
- Back-to-back and ignored start: hold start_i = 1 continuously with p6 -> start accepted only in IDLE/DONE; done_o pulses every 7 cycles; start_i during RUN does not disturb the round sequence.
- Reset mid-run: assert resetb_i low during round 5 of p12 -> all outputs return to 0 asynchronously within the cycle; no done_o follows; a new start after release completes normally.
- Reserved mode: mode_i = 11 -> behaves as p12 (12 rounds, identical result to mode_i = 00 for the same state_i).
